// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console write-side controller.
// Optional feature macro: TEXT_CONSOLE_SCROLL_EN (hardware scroll via top_row).
package text_console_pkg;

  localparam int COL_W  = 6;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = 12;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [COL_W-1:0] LAST_COL = '1;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

  // Buffer address of a character cell: physical row in the upper bits.
  function automatic logic [ADDR_W-1:0] buf_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte-stream handshake into the text console (data, valid/ready, clear request).
interface text_console_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clear;

  modport master (output in_data, output in_valid, output clear, input in_ready);
  modport slave  (input in_data, input in_valid, input clear, output in_ready);
endinterface

// File: rtl/text_console_fill.sv
// Fill sequencer: writes a run of consecutive addresses, either one 64-cell
// line starting at {row, 0} or the whole 4096-cell buffer starting at 0.
// The first write is registered on the edge that samples start; done is high
// during the cycle of the last write.
module text_console_fill
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_all,
  input  logic [ROW_W-1:0]  start_row,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic              active_reg;
  logic              all_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] start_base;
  logic [ADDR_W-1:0] last_cnt;

  assign start_base = start_all ? '0 : buf_addr(start_row, '0);
  assign last_cnt   = all_reg ? 12'd4095 : 12'd63;

  // Run the address counter and register one write per active cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      all_reg    <= 1'b0;
      base_reg   <= '0;
      cnt_reg    <= '0;
      we         <= 1'b0;
      addr       <= '0;
      done       <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (start) begin
        active_reg <= 1'b1;
        all_reg    <= start_all;
        base_reg   <= start_base;
        cnt_reg    <= 12'd1;
        we         <= 1'b1;
        addr       <= start_base;
      end else if (active_reg) begin
        we      <= 1'b1;
        addr    <= base_reg + cnt_reg;
        cnt_reg <= cnt_reg + 12'd1;
        if (cnt_reg == last_cnt) begin
          active_reg <= 1'b0;
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Write-side controller for the 64x64 character buffer: cursor keeping,
// control-byte handling, clear-screen / clear-line fills and scroll offset.
// Optional feature macro: TEXT_CONSOLE_SCROLL_EN. When undefined, top_row
// stays 0 and running off the bottom wraps the cursor to row 0 instead.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                rst_n,
  text_console_ctrl_if.slave  in_if,
  output logic                ram_cea,
  output logic [ADDR_W-1:0]   ram_ada,
  output logic [7:0]          ram_din,
  output logic [ROW_W-1:0]    top_row,
  output logic [COL_W-1:0]    cursor_col,
  output logic [ROW_W-1:0]    cursor_row,
  output logic                busy
);

  state_t            state_reg;
  logic              clear_pending_reg;
  logic              kick_reg;          // start a line fill next cycle (after a char write)
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ROW_W-1:0]  top_reg;
  logic              char_we_reg;
  logic [ADDR_W-1:0] char_addr_reg;
  logic [7:0]        char_din_reg;

  logic              accept;
  logic [ROW_W-1:0]  phys_row;
  logic              start_now;
  logic              start_now_all;
  logic              fill_start;
  logic              fill_all;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_done;

  // A clear request on the input wins over a byte offered in the same cycle.
  assign in_if.in_ready = (state_reg == IDLE) && !clear_pending_reg && !in_if.clear;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign phys_row       = row_reg + top_reg;

  // Fills that must write on the very next edge are started combinationally.
  always_comb begin
    start_now     = 1'b0;
    start_now_all = 1'b0;
    if (state_reg == IDLE) begin
      if (in_if.clear || clear_pending_reg) begin
        start_now     = 1'b1;
        start_now_all = 1'b1;
      end else if (accept) begin
        if (in_if.in_data == CH_FF) begin
          start_now     = 1'b1;
          start_now_all = 1'b1;
        end else if (in_if.in_data == CH_LF && row_reg == LAST_ROW) begin
          start_now = 1'b1;
        end
      end
    end
  end

  // The row being cleared is always the old top_row (the new bottom line when
  // scrolling, physical row 0 when wrapping with scroll disabled).
  assign fill_start = kick_reg | start_now;
  assign fill_all   = start_now ? start_now_all : (state_reg == CLR_ALL);

  text_console_fill u_fill (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (fill_start),
    .start_all (fill_all),
    .start_row (top_reg),
    .we        (fill_we),
    .addr      (fill_addr),
    .done      (fill_done)
  );

  // Main state machine: cursor, scroll offset, pending clear and char writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= CLR_ALL;
      clear_pending_reg <= 1'b0;
      kick_reg          <= 1'b1;
      col_reg           <= '0;
      row_reg           <= '0;
      top_reg           <= '0;
      char_we_reg       <= 1'b0;
      char_addr_reg     <= '0;
      char_din_reg      <= '0;
    end else begin
      kick_reg    <= 1'b0;
      char_we_reg <= 1'b0;
      case (state_reg)
        CLR_ALL: begin
          if (fill_done) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            top_reg   <= '0;
          end
        end
        CLR_LINE: begin
          if (in_if.clear) clear_pending_reg <= 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
          if (kick_reg) top_reg <= top_reg + 6'd1;
`endif
          if (fill_done) state_reg <= IDLE;
        end
        IDLE: begin
          if (in_if.clear || clear_pending_reg) begin
            clear_pending_reg <= 1'b0;
            state_reg         <= CLR_ALL;
          end else if (accept) begin
            case (in_if.in_data)
              CH_LF: begin
                col_reg <= '0;
                if (row_reg != LAST_ROW) begin
                  row_reg <= row_reg + 6'd1;
                end else begin
                  state_reg <= CLR_LINE;
`ifdef TEXT_CONSOLE_SCROLL_EN
                  top_reg <= top_reg + 6'd1;
`else
                  row_reg <= '0;
`endif
                end
              end
              CH_CR: col_reg <= '0;
              CH_BS: if (col_reg != '0) col_reg <= col_reg - 6'd1;
              CH_FF: state_reg <= CLR_ALL;
              default: begin
                char_we_reg   <= 1'b1;
                char_addr_reg <= buf_addr(phys_row, col_reg);
                char_din_reg  <= in_if.in_data;
                if (col_reg == LAST_COL) begin
                  col_reg <= '0;
                  if (row_reg != LAST_ROW) begin
                    row_reg <= row_reg + 6'd1;
                  end else begin
                    // Line fill follows the char write; top_row moves with it.
                    state_reg <= CLR_LINE;
                    kick_reg  <= 1'b1;
`ifndef TEXT_CONSOLE_SCROLL_EN
                    row_reg <= '0;
`endif
                  end
                end else begin
                  col_reg <= col_reg + 6'd1;
                end
              end
            endcase
          end
        end
        default: state_reg <= CLR_ALL;
      endcase
    end
  end

  assign ram_cea    = fill_we | char_we_reg;
  assign ram_ada    = fill_we ? fill_addr : char_addr_reg;
  assign ram_din    = fill_we ? FILL_CHAR : char_din_reg;
  assign top_row    = top_reg;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;
  assign busy       = (state_reg != IDLE);

endmodule
